// File: rtl/cp_datapath_if.sv
// cp_datapath_if: bundles the control-point word, operand bus and all
// datapath results exchanged between the one-hot controller and cp_datapath.
// The controller side uses the master modport, and the datapath uses slave.
interface cp_datapath_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic [4:0]    cp;
  logic [W-1:0]  data_in;
  logic [W-1:0]  acc;
  logic          V;
  logic          Z;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [CW-1:0] step_cnt;
  logic          step_wrap;

  modport master (
    output cp,
    output data_in,
    input  acc,
    input  V,
    input  Z,
    input  result,
    input  result_valid,
    input  step_cnt,
    input  step_wrap
  );

  modport slave (
    input  cp,
    input  data_in,
    output acc,
    output V,
    output Z,
    output result,
    output result_valid,
    output step_cnt,
    output step_wrap
  );
endinterface

// File: rtl/cp_datapath.sv
// cp_datapath: accumulator datapath stage steered by a 5-bit control-point word.
// cp[4:3] selects NOP/LOAD/ADD/SUB, cp[2] captures the V/Z flags, cp[1] stores
// the new accumulator value into result, and cp[0] advances the step counter.
// Optional feature: define CP_DATAPATH_SATURATE_EN to clamp ADD/SUB overflow
// to the most positive or most negative value instead of wrapping.
// W and CW must match the parameters of the connected cp_datapath_if instance.
module cp_datapath #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  cp_datapath_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  op_t           op;
  logic          flag_en;
  logic          store_en;
  logic          step_en;

  logic [W-1:0]  acc_q;
  logic          v_q;
  logic          z_q;
  logic [W-1:0]  result_q;
  logic          result_valid_q;
  logic [CW-1:0] step_cnt_q;
  logic          step_wrap_q;

  logic [W-1:0]  sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  wrap_val;
  logic [W-1:0]  acc_next;
  logic          ovf;

  assign op       = op_t'(bus.cp[4:3]);
  assign flag_en  = bus.cp[2];
  assign store_en = bus.cp[1];
  assign step_en  = bus.cp[0];

  // Next accumulator value and signed overflow for the selected operation
  always_comb begin
    sum      = acc_q + bus.data_in;
    diff     = acc_q - bus.data_in;
    wrap_val = acc_q;
    ovf      = 1'b0;
    case (op)
      OP_NOP: begin
        wrap_val = acc_q;
      end
      OP_LOAD: begin
        wrap_val = bus.data_in;
      end
      OP_ADD: begin
        wrap_val = sum;
        ovf      = (acc_q[W-1] == bus.data_in[W-1]) && (sum[W-1] != acc_q[W-1]);
      end
      OP_SUB: begin
        wrap_val = diff;
        ovf      = (acc_q[W-1] != bus.data_in[W-1]) && (diff[W-1] != acc_q[W-1]);
      end
      default: begin
        wrap_val = acc_q;
      end
    endcase
    // Overflow direction always follows acc's sign for both ADD and SUB,
    // so the clamp value is picked from acc_q's MSB.
`ifdef CP_DATAPATH_SATURATE_EN
    acc_next = ovf ? (acc_q[W-1] ? MIN_NEG : MAX_POS) : wrap_val;
`else
    acc_next = wrap_val;
`endif
  end

  // Registered state: accumulator, flags, stored result and step counter
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q          <= '0;
      v_q            <= 1'b0;
      z_q            <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      step_cnt_q     <= '0;
      step_wrap_q    <= 1'b0;
    end else begin
      acc_q <= acc_next;
      if (flag_en) begin
        v_q <= ovf;
        z_q <= (acc_next == '0);
      end
      if (store_en) begin
        result_q       <= acc_next;
        result_valid_q <= 1'b1;
      end else begin
        result_valid_q <= 1'b0;
      end
      if (step_en) begin
        step_cnt_q  <= step_cnt_q + 1'b1;
        step_wrap_q <= &step_cnt_q;
      end else begin
        step_wrap_q <= 1'b0;
      end
    end
  end

  assign bus.acc          = acc_q;
  assign bus.V            = v_q;
  assign bus.Z            = z_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.step_cnt     = step_cnt_q;
  assign bus.step_wrap    = step_wrap_q;

endmodule

// File: tb/tb_cp_datapath.sv
// tb_cp_datapath: directed-vector bench for cp_datapath (W=8, CW=4).
// An integer-arithmetic model tracks the expected outputs and is compared
// against the DUT every cycle; literal expectations pin key scenarios.
// Honours CP_DATAPATH_SATURATE_EN the same way the design does.
module tb_cp_datapath;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic clk;
  logic clr;

  int tests_run;
  int tests_failed;

  cp_datapath_if #(.W(W), .CW(CW)) bus ();

  cp_datapath #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, kept as plain signed integers
  int m_acc;
  int m_v;
  int m_z;
  int m_result;
  int m_rv;
  int m_step;
  int m_wrap;
  bit m_valid;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic [4:0] cp_val,
                               input logic [W-1:0] d);
    @(negedge clk);
    clr         = c;
    bus.cp      = cp_val;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Model: evaluate the operation with full-precision integers each edge
  always @(posedge clk) begin
    int a;
    int d;
    int r;
    int op;
    int ovf;
    if (clr) begin
      m_acc = 0; m_v = 0; m_z = 0; m_result = 0; m_rv = 0; m_step = 0; m_wrap = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      a   = m_acc;
      d   = int'($signed(bus.data_in));
      op  = int'(bus.cp[4:3]);
      r   = (op == 0) ? a : (op == 1) ? d : (op == 2) ? a + d : a - d;
      ovf = (op >= 2 && (r > MAXV || r < MINV)) ? 1 : 0;
      if (ovf != 0) begin
`ifdef CP_DATAPATH_SATURATE_EN
        r = (r > MAXV) ? MAXV : MINV;
`else
        r = (r > MAXV) ? r - 2 ** W : r + 2 ** W;
`endif
      end
      if (bus.cp[2]) begin
        m_v = ovf;
        m_z = (r == 0) ? 1 : 0;
      end
      if (bus.cp[1]) begin
        m_result = r;
        m_rv     = 1;
      end else begin
        m_rv = 0;
      end
      if (bus.cp[0]) begin
        m_wrap = (m_step == 2 ** CW - 1) ? 1 : 0;
        m_step = (m_step + 1) % (2 ** CW);
      end else begin
        m_wrap = 0;
      end
      m_acc = r;
    end
  end

  // Compare every output with the model on each falling edge
  always @(negedge clk) begin
    logic [W-1:0] e_acc;
    logic [W-1:0] e_res;
    logic [CW-1:0] e_step;
    if (m_valid) begin
      e_acc  = m_acc[W-1:0];
      e_res  = m_result[W-1:0];
      e_step = m_step[CW-1:0];
      checkOutput("model acc", 32'(bus.acc), 32'(e_acc));
      checkOutput("model V", 32'(bus.V), 32'(m_v));
      checkOutput("model Z", 32'(bus.Z), 32'(m_z));
      checkOutput("model result", 32'(bus.result), 32'(e_res));
      checkOutput("model result_valid", 32'(bus.result_valid), 32'(m_rv));
      checkOutput("model step_cnt", 32'(bus.step_cnt), 32'(e_step));
      checkOutput("model step_wrap", 32'(bus.step_wrap), 32'(m_wrap));
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " acc"}, 32'(bus.acc), 32'h00);
    checkOutput({tag, " V"}, 32'(bus.V), 32'd0);
    checkOutput({tag, " Z"}, 32'(bus.Z), 32'd0);
    checkOutput({tag, " result"}, 32'(bus.result), 32'h00);
    checkOutput({tag, " result_valid"}, 32'(bus.result_valid), 32'd0);
    checkOutput({tag, " step_cnt"}, 32'(bus.step_cnt), 32'd0);
    checkOutput({tag, " step_wrap"}, 32'(bus.step_wrap), 32'd0);
  endtask

  // Directed stimulus with hand-computed expectations
  initial begin
    logic [4:0] mix_cp [8];
    logic [7:0] mix_d  [8];
    tests_run    = 0;
    tests_failed = 0;
    m_valid      = 1'b0;
    clr          = 1'b1;
    bus.cp       = 5'b11111;
    bus.data_in  = 8'h55;

    // Reset held two clocks with every control point active
    applyStimulus(1'b1, 5'b11111, 8'h55);
    applyStimulus(1'b1, 5'b11111, 8'h55);
    checkResetState("reset");

    // LOAD then ADD with flag update
    applyStimulus(1'b0, 5'b01000, 8'h05);
    checkOutput("load acc", 32'(bus.acc), 32'h05);
    checkOutput("load V", 32'(bus.V), 32'd0);
    checkOutput("load Z", 32'(bus.Z), 32'd0);
    applyStimulus(1'b0, 5'b10100, 8'h03);
    checkOutput("add acc", 32'(bus.acc), 32'h08);
    checkOutput("add V", 32'(bus.V), 32'd0);
    checkOutput("add Z", 32'(bus.Z), 32'd0);

    // Positive ADD overflow
    applyStimulus(1'b0, 5'b01000, 8'h7F);
    applyStimulus(1'b0, 5'b10100, 8'h01);
`ifdef CP_DATAPATH_SATURATE_EN
    checkOutput("add ovf acc", 32'(bus.acc), 32'h7F);
    checkOutput("model pin add ovf", 32'(m_acc), 32'(127));
`else
    checkOutput("add ovf acc", 32'(bus.acc), 32'h80);
    checkOutput("model pin add ovf", 32'(m_acc), 32'(-128));
`endif
    checkOutput("add ovf V", 32'(bus.V), 32'd1);
    checkOutput("add ovf Z", 32'(bus.Z), 32'd0);

    // LOAD with store, V held since flags not updated
    applyStimulus(1'b0, 5'b01010, 8'h05);
    checkOutput("store5 result", 32'(bus.result), 32'h05);
    checkOutput("store5 valid", 32'(bus.result_valid), 32'd1);
    checkOutput("held V", 32'(bus.V), 32'd1);

    // SUB to zero with flags and store, then valid drops
    applyStimulus(1'b0, 5'b11110, 8'h05);
    checkOutput("sub0 acc", 32'(bus.acc), 32'h00);
    checkOutput("sub0 Z", 32'(bus.Z), 32'd1);
    checkOutput("sub0 V", 32'(bus.V), 32'd0);
    checkOutput("sub0 result", 32'(bus.result), 32'h00);
    checkOutput("sub0 valid", 32'(bus.result_valid), 32'd1);
    applyStimulus(1'b0, 5'b00000, 8'h00);
    checkOutput("valid pulse end", 32'(bus.result_valid), 32'd0);
    checkOutput("nop Z held", 32'(bus.Z), 32'd1);

    // Negative SUB overflow: -128 - 1
    applyStimulus(1'b0, 5'b01000, 8'h80);
    applyStimulus(1'b0, 5'b11100, 8'h01);
`ifdef CP_DATAPATH_SATURATE_EN
    checkOutput("sub ovf acc", 32'(bus.acc), 32'h80);
`else
    checkOutput("sub ovf acc", 32'(bus.acc), 32'h7F);
`endif
    checkOutput("sub ovf V", 32'(bus.V), 32'd1);

    // Step counter full lap
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 5'b00001, 8'h00);
      checkOutput("step_cnt", 32'(bus.step_cnt), 32'((i + 1) % 16));
      checkOutput("step_wrap", 32'(bus.step_wrap), (i == 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 5'b00000, 8'h00);
    checkOutput("wrap pulse end", 32'(bus.step_wrap), 32'd0);

    // Build stale state, then reset with all control points active
    applyStimulus(1'b0, 5'b01000, 8'h7F);
    applyStimulus(1'b0, 5'b10110, 8'h01);
    checkOutput("pre-clr V", 32'(bus.V), 32'd1);
    applyStimulus(1'b0, 5'b01001, 8'h10);
    checkOutput("pre-clr acc", 32'(bus.acc), 32'h10);
    applyStimulus(1'b1, 5'b11111, 8'h01);
    checkResetState("clr override");
    applyStimulus(1'b0, 5'b10100, 8'h03);
    checkOutput("post-clr acc", 32'(bus.acc), 32'h03);
    checkOutput("post-clr model pin", 32'(m_acc), 32'd3);

    // Mixed combinations covered by the model
    mix_cp = '{5'b11111, 5'b10111, 5'b01110, 5'b11101, 5'b10100, 5'b00110, 5'b11111, 5'b10101};
    mix_d  = '{8'h7F,    8'hC0,    8'h81,    8'h7F,    8'hFF,    8'h00,    8'h80,    8'h40};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, mix_cp[i], mix_d[i]);
    end
    applyStimulus(1'b0, 5'b00000, 8'h00);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
